// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched: sequencer for one leading (DIF) NTT butterfly stage.
// Starts a job when an input slot is full, an output slot is free and the ROB
// holds an op; then issues one butterfly line pair per cycle, delays the write
// addresses to line up with the datapath, and closes with finish pulses.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   rob_empty_i              no pending NTT op (blocks job start)
//   cfg_length_i/log2_len_i  polynomial length N and log2(N), latched at start
//   in_empty_i, in_*_i       input FIFO status and slot metadata
//   in_addrA_o/in_addrB_o    read addresses (upper/lower butterfly line)
//   in_rd_finish_o           active-low pulse releasing the input slot
//   bf_valid_o, bf_bypass_o  issue strobe, job-level pass-through
//   rou_addr_o               twiddle line offset within the group
//   out_full_i               output FIFO has no free slot
//   out_addrA_o/out_addrB_o  write addresses aligned to the datapath output
//   out_wen_o                write strobe for both lines
//   out_wr_finish_o          active-low pulse committing the output slot
//   out_*_o                  metadata latched at job start
//   busy_o                   a job is in progress
module ntt_stage_sched #(
    parameter int ADDR_WIDTH    = 9,
    parameter int LINE_SIZE     = 4,
    parameter int STAGE_NUM     = 10,
    parameter int BF_LATENCY    = 6,
    parameter int OPCODE_WIDTH  = 4,
    parameter int RLWE_ID_WIDTH = 3,
    parameter int POLY_ID_WIDTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rob_empty_i,
    input  logic [ADDR_WIDTH+2:0]    cfg_length_i,
    input  logic [4:0]               cfg_log2_len_i,
    input  logic                     in_empty_i,
    input  logic [OPCODE_WIDTH-1:0]  in_opcode_i,
    input  logic [RLWE_ID_WIDTH-1:0] in_rlwe_id_i,
    input  logic [POLY_ID_WIDTH-1:0] in_poly_id_i,
    output logic [ADDR_WIDTH-1:0]    in_addrA_o,
    output logic [ADDR_WIDTH-1:0]    in_addrB_o,
    output logic                     in_rd_finish_o,
    output logic                     bf_valid_o,
    output logic                     bf_bypass_o,
    output logic [ADDR_WIDTH-1:0]    rou_addr_o,
    input  logic                     out_full_i,
    output logic [ADDR_WIDTH-1:0]    out_addrA_o,
    output logic [ADDR_WIDTH-1:0]    out_addrB_o,
    output logic                     out_wen_o,
    output logic                     out_wr_finish_o,
    output logic [OPCODE_WIDTH-1:0]  out_opcode_o,
    output logic [RLWE_ID_WIDTH-1:0] out_rlwe_id_o,
    output logic [POLY_ID_WIDTH-1:0] out_poly_id_o,
    output logic                     busy_o
);

    localparam int AW  = ADDR_WIDTH;
    localparam int LSL = $clog2(LINE_SIZE);
    localparam int LG  = STAGE_NUM - LSL;
    localparam int PD  = BF_LATENCY + 1;
    localparam int DW  = $clog2(BF_LATENCY + 2);
    localparam logic [AW-1:0] G    = AW'(1 << LG);
    localparam logic [AW-1:0] MASK = AW'((1 << LG) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state_q;
    logic [AW-1:0]            idx_q;
    logic [AW-1:0]            idx_d;
    logic [AW-1:0]            last_q;
    logic [DW-1:0]            dcnt_q;
    logic                     byp_q;
    logic                     valid_q;
    logic [AW-1:0]            addr_a_q;
    logic [AW-1:0]            addr_b_q;
    logic [AW-1:0]            rou_q;
    logic                     rdf_q;
    logic                     wrf_q;
    logic [OPCODE_WIDTH-1:0]  op_q;
    logic [RLWE_ID_WIDTH-1:0] rlwe_q;
    logic [POLY_ID_WIDTH-1:0] poly_q;
    logic [2*AW:0]            pipe_q [PD];

    logic          start;
    logic          byp_cfg;
    logic [AW-1:0] last_cfg;

    assign start   = !in_empty_i && !out_full_i && !rob_empty_i;
    // Short polynomials never reach this stage's span: pass lines through.
    assign byp_cfg = cfg_log2_len_i < 5'(STAGE_NUM + 1);
    assign last_cfg = AW'((byp_cfg ? (cfg_length_i >> LSL)
                                   : (cfg_length_i >> (LSL + 1)))
                          - (AW + 3)'(1));
    assign idx_d = idx_q + AW'(1);

    // Insert a zero bit at position LG: upper line of the butterfly pair.
    function automatic logic [AW-1:0] calc_a(input logic [AW-1:0] i,
                                             input logic byp);
        logic [AW-1:0] hi;
        hi = (i >> LG) << (LG + 1);
        return byp ? i : (hi | (i & MASK));
    endfunction

    function automatic logic [AW-1:0] calc_b(input logic [AW-1:0] i,
                                             input logic byp);
        return byp ? i : (calc_a(i, 1'b0) | G);
    endfunction

    function automatic logic [AW-1:0] calc_r(input logic [AW-1:0] i,
                                             input logic byp);
        return byp ? '0 : (i & MASK);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            last_q   <= '0;
            dcnt_q   <= '0;
            byp_q    <= 1'b0;
            valid_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            rou_q    <= '0;
            rdf_q    <= 1'b1;
            wrf_q    <= 1'b1;
            op_q     <= '0;
            rlwe_q   <= '0;
            poly_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        state_q  <= RUN;
                        idx_q    <= '0;
                        last_q   <= last_cfg;
                        byp_q    <= byp_cfg;
                        op_q     <= in_opcode_i;
                        rlwe_q   <= in_rlwe_id_i;
                        poly_q   <= in_poly_id_i;
                        valid_q  <= 1'b1;
                        addr_a_q <= calc_a('0, byp_cfg);
                        addr_b_q <= calc_b('0, byp_cfg);
                        rou_q    <= calc_r('0, byp_cfg);
                    end
                end
                RUN: begin
                    // Terminate on compare so a full-range count never wraps.
                    if (idx_q == last_q) begin
                        state_q <= DRAIN;
                        valid_q <= 1'b0;
                        dcnt_q  <= DW'(BF_LATENCY);
                    end else begin
                        idx_q    <= idx_d;
                        valid_q  <= 1'b1;
                        addr_a_q <= calc_a(idx_d, byp_q);
                        addr_b_q <= calc_b(idx_d, byp_q);
                        rou_q    <= calc_r(idx_d, byp_q);
                    end
                end
                DRAIN: begin
                    if (dcnt_q == '0) begin
                        state_q <= DONE;
                        rdf_q   <= 1'b0;
                        wrf_q   <= 1'b0;
                    end else begin
                        dcnt_q <= dcnt_q - DW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    rdf_q   <= 1'b1;
                    wrf_q   <= 1'b1;
                    byp_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write side: RAM read (1 cycle) plus datapath depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < PD; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= {valid_q, addr_a_q, addr_b_q};
            for (int i = 1; i < PD; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign {out_wen_o, out_addrA_o, out_addrB_o} = pipe_q[PD-1];

    assign in_addrA_o      = addr_a_q;
    assign in_addrB_o      = addr_b_q;
    assign rou_addr_o      = rou_q;
    assign bf_valid_o      = valid_q;
    assign bf_bypass_o     = byp_q;
    assign in_rd_finish_o  = rdf_q;
    assign out_wr_finish_o = wrf_q;
    assign out_opcode_o    = op_q;
    assign out_rlwe_id_o   = rlwe_q;
    assign out_poly_id_o   = poly_q;
    assign busy_o          = state_q != IDLE;

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Bench for ntt_stage_sched: job-level model checked every cycle plus
// hand-computed literal expectations for the directed jobs.
module tb_ntt_stage_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rob_empty = 1'b1;
    logic [12:0] cfg_len = '0;
    logic [4:0]  cfg_lg = '0;
    logic        in_empty = 1'b1;
    logic [3:0]  in_op = 4'h5;
    logic [2:0]  in_rlwe = 3'd3;
    logic [1:0]  in_poly = 2'd0;
    logic        out_full = 1'b0;

    logic [9:0] in_addrA_o, in_addrB_o, rou_addr_o;
    logic [9:0] out_addrA_o, out_addrB_o;
    logic       in_rd_finish_o, bf_valid_o, bf_bypass_o;
    logic       out_wen_o, out_wr_finish_o, busy_o;
    logic [3:0] out_opcode_o;
    logic [2:0] out_rlwe_id_o;
    logic [1:0] out_poly_id_o;

    ntt_stage_sched #(
        .ADDR_WIDTH(10), .LINE_SIZE(4), .STAGE_NUM(10), .BF_LATENCY(6),
        .OPCODE_WIDTH(4), .RLWE_ID_WIDTH(3), .POLY_ID_WIDTH(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .rob_empty_i(rob_empty),
        .cfg_length_i(cfg_len), .cfg_log2_len_i(cfg_lg),
        .in_empty_i(in_empty), .in_opcode_i(in_op),
        .in_rlwe_id_i(in_rlwe), .in_poly_id_i(in_poly),
        .in_addrA_o(in_addrA_o), .in_addrB_o(in_addrB_o),
        .in_rd_finish_o(in_rd_finish_o), .bf_valid_o(bf_valid_o),
        .bf_bypass_o(bf_bypass_o), .rou_addr_o(rou_addr_o),
        .out_full_i(out_full),
        .out_addrA_o(out_addrA_o), .out_addrB_o(out_addrB_o),
        .out_wen_o(out_wen_o), .out_wr_finish_o(out_wr_finish_o),
        .out_opcode_o(out_opcode_o), .out_rlwe_id_o(out_rlwe_id_o),
        .out_poly_id_o(out_poly_id_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Job-level model: a job occupies cycles k=0..P+7 after acceptance.
    bit m_started = 0;
    bit m_act = 0;
    int m_k = 0;
    int m_p = 0;
    bit m_byp = 0;
    int m_op = 0, m_rl = 0, m_po = 0;

    always @(posedge clk) begin
        m_started = 1;
        if (rst) begin
            m_act = 0;
            m_op = 0; m_rl = 0; m_po = 0;
        end else if (m_act) begin
            if (m_k == m_p + 7) m_act = 0;
            else m_k++;
        end else if (!in_empty && !out_full && !rob_empty) begin
            m_act = 1;
            m_k = 0;
            m_byp = cfg_len < 2048;
            m_p = m_byp ? cfg_len / 4 : cfg_len / 8;
            m_op = in_op; m_rl = in_rlwe; m_po = in_poly;
        end
    end

    function automatic int ea(int k, bit byp);
        return byp ? k : (k / 256) * 512 + (k % 256);
    endfunction

    function automatic int eb(int k, bit byp);
        return byp ? k : ea(k, byp) + 256;
    endfunction

    function automatic int er(int k, bit byp);
        return byp ? 0 : k % 256;
    endfunction

    always @(negedge clk) begin : cmp
        bit v, w, f;
        if (m_started) begin
            v = m_act && m_k < m_p;
            w = m_act && m_k >= 7 && m_k < m_p + 7;
            f = !(m_act && m_k == m_p + 7);
            chk("busy", busy_o, m_act);
            chk("bf_valid", bf_valid_o, v);
            chk("bf_bypass", bf_bypass_o, m_act && m_byp);
            chk("out_wen", out_wen_o, w);
            chk("rd_finish", in_rd_finish_o, f);
            chk("wr_finish", out_wr_finish_o, f);
            chk("opcode", out_opcode_o, m_op);
            chk("rlwe", out_rlwe_id_o, m_rl);
            chk("poly", out_poly_id_o, m_po);
            if (v) begin
                chk("addrA", in_addrA_o, ea(m_k, m_byp));
                chk("addrB", in_addrB_o, eb(m_k, m_byp));
                chk("rou", rou_addr_o, er(m_k, m_byp));
            end
            if (w) begin
                chk("out_addrA", out_addrA_o, ea(m_k - 7, m_byp));
                chk("out_addrB", out_addrB_o, eb(m_k - 7, m_byp));
            end
        end
    end

    int r_waits, r_fin, r_wen, r_nv, r_pa, r_pb, r_pr;
    int r_la, r_lb, r_lr, r_byp, r_poly, r_rbusy, r_rwen;

    task automatic run_job(input int n, input int lg, input int poly,
                           input int probe, input bit keep,
                           input int next_poly, input int rst_at);
        int c;
        cfg_len = 13'(n); cfg_lg = 5'(lg); in_poly = 2'(poly);
        in_empty = 0; out_full = 0; rob_empty = 0;
        r_waits = 0; r_fin = 0; r_wen = 0; r_nv = 0;
        r_pa = -1; r_pb = -1; r_pr = -1; r_la = -1; r_lb = -1; r_lr = -1;
        r_byp = -1; r_poly = -1; r_rbusy = -1; r_rwen = -1;
        while (!busy_o && r_waits < 10) begin
            @(negedge clk);
            r_waits++;
        end
        chk("start", busy_o, 1);
        in_poly = 2'(next_poly);
        if (!keep) begin
            in_empty = 1; out_full = 1; rob_empty = 1;
            cfg_len = 13'd16; cfg_lg = 5'd4;
        end
        c = 1;
        while (busy_o && c < 1200) begin
            if (bf_valid_o) begin
                r_nv++;
                r_la = in_addrA_o; r_lb = in_addrB_o; r_lr = rou_addr_o;
            end
            if (c == probe) begin
                r_pa = in_addrA_o; r_pb = in_addrB_o; r_pr = rou_addr_o;
                r_byp = bf_bypass_o; r_poly = out_poly_id_o;
            end
            if (out_wen_o && r_wen == 0) r_wen = c;
            if (!in_rd_finish_o) r_fin = c;
            if (c == rst_at) begin
                rst = 1;
                @(negedge clk);
                rst = 0;
                r_rbusy = busy_o; r_rwen = out_wen_o;
                break;
            end
            @(negedge clk);
            c++;
        end
        chk("job_end", busy_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", bf_valid_o, 0);
        chk("rst_wen", out_wen_o, 0);
        chk("rst_rdf", in_rd_finish_o, 1);
        chk("rst_wrf", out_wr_finish_o, 1);
        chk("rst_addrA", in_addrA_o, 0);
        chk("rst_addrB", in_addrB_o, 0);
        chk("rst_rou", rou_addr_o, 0);
        chk("rst_oaddrA", out_addrA_o, 0);
        chk("rst_meta", {out_opcode_o, out_rlwe_id_o, out_poly_id_o}, 0);
        rst = 0;
        @(negedge clk);

        // N=2048: full-span stage, 256 pairs.
        run_job(2048, 11, 0, 1, 0, 0, 0);
        chk("n2k_wait", r_waits, 1);
        chk("n2k_firstA", r_pa, 0);
        chk("n2k_firstB", r_pb, 256);
        chk("n2k_firstR", r_pr, 0);
        chk("n2k_lastA", r_la, 255);
        chk("n2k_lastB", r_lb, 511);
        chk("n2k_lastR", r_lr, 255);
        chk("n2k_issues", r_nv, 256);
        chk("n2k_wen1st", r_wen, 8);
        chk("n2k_finish", r_fin, 264);
        chk("n2k_byp", r_byp, 0);
        @(negedge clk);

        // N=4096: second group starts at line 512.
        run_job(4096, 12, 1, 257, 0, 1, 0);
        chk("n4k_A256", r_pa, 512);
        chk("n4k_B256", r_pb, 768);
        chk("n4k_R256", r_pr, 0);
        chk("n4k_issues", r_nv, 512);
        chk("n4k_lastA", r_la, 767);
        chk("n4k_lastB", r_lb, 1023);
        chk("n4k_finish", r_fin, 520);
        @(negedge clk);

        // N=1024: bypass job.
        run_job(1024, 10, 2, 1, 0, 2, 0);
        chk("byp_flag", r_byp, 1);
        chk("byp_issues", r_nv, 256);
        chk("byp_lastA", r_la, 255);
        chk("byp_lastB", r_lb, 255);
        chk("byp_lastR", r_lr, 0);
        chk("byp_finish", r_fin, 264);
        chk("byp_poly", r_poly, 2);
        @(negedge clk);

        // Start gating by out_full, then by rob_empty.
        cfg_len = 13'd64; cfg_lg = 5'd6;
        in_empty = 0; out_full = 1; rob_empty = 0;
        repeat (4) @(negedge clk);
        chk("gate_full", busy_o, 0);
        out_full = 0;
        @(negedge clk);
        chk("gate_release", busy_o, 1);
        in_empty = 1; out_full = 1; rob_empty = 1;
        for (int i = 0; i < 100 && busy_o; i++) @(negedge clk);
        chk("gate_done", busy_o, 0);
        in_empty = 0; out_full = 0; rob_empty = 1;
        repeat (4) @(negedge clk);
        chk("gate_rob", busy_o, 0);
        in_empty = 1;
        @(negedge clk);

        // Back-to-back jobs with per-job metadata.
        in_rlwe = 3'd3;
        run_job(64, 6, 0, 1, 1, 1, 0);
        chk("b2b1_poly", r_poly, 0);
        chk("b2b1_issues", r_nv, 16);
        chk("b2b1_finish", r_fin, 24);
        run_job(64, 6, 1, 1, 0, 1, 0);
        chk("b2b2_wait", r_waits, 1);
        chk("b2b2_poly", r_poly, 1);
        chk("b2b2_rlwe", out_rlwe_id_o, 3);
        chk("b2b2_issues", r_nv, 16);
        @(negedge clk);

        // Reset mid-job at idx=100.
        run_job(2048, 11, 0, 101, 0, 0, 101);
        chk("rst_idx100A", r_pa, 100);
        chk("rst_idx100B", r_pb, 356);
        chk("rst_midbusy", r_rbusy, 0);
        chk("rst_midwen", r_rwen, 0);
        chk("rst_nofinish", r_fin, 0);
        repeat (3) @(negedge clk);
        run_job(2048, 11, 0, 1, 0, 0, 0);
        chk("post_rst_A", r_pa, 0);
        chk("post_rst_B", r_pb, 256);
        chk("post_rst_fin", r_fin, 264);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
